// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and the round-robin pick function for rr_stream_arbiter.
// Vectors are carried at RR_MAX_PORTS bits; callers size-cast in and slice out.
package rr_stream_arbiter_pkg;

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    localparam int RR_MAX_PORTS = 32;
    localparam int RR_IDX_W     = $clog2(RR_MAX_PORTS);

    typedef logic [RR_MAX_PORTS-1:0] rr_vec_t;

    // One-hot of the first set request found walking ptr, ptr+1, ... circularly.
    function automatic rr_vec_t rr_pick(input rr_vec_t req, input int unsigned ptr,
                                        input int unsigned ports);
        rr_vec_t             grant;
        logic                found;
        int unsigned         idx;
        logic [RR_IDX_W-1:0] sel;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_MAX_PORTS; k++) begin
            if (k < ports) begin
                idx = ptr + k;
                if (idx >= ports) begin
                    idx = idx - ports;
                end
                sel = RR_IDX_W'(idx);
                if (!found && req[sel]) begin
                    grant[sel] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_stream_arbiter_if.sv
// Stream bundle between PORTS requesters, the arbiter and one downstream consumer.
interface rr_stream_arbiter_if #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [PORTS*DATA_WIDTH-1:0] i_data;
    logic [PORTS-1:0]            i_valid;
    logic [PORTS-1:0]            i_last;
    logic [PORTS-1:0]            o_ready;
    logic [DATA_WIDTH-1:0]       o_data;
    logic                        o_valid;
    logic                        o_last;
    logic                        i_ready;
    logic [PORTS-1:0]            o_grant;

    modport slave (
        input  i_data, i_valid, i_last, i_ready,
        output o_ready, o_data, o_valid, o_last, o_grant
    );

    modport master (
        output i_data, i_valid, i_last, i_ready,
        input  o_ready, o_data, o_valid, o_last, o_grant
    );
endinterface

// File: rtl/rr_stream_arbiter_onehot_mux.sv
// AND-OR multiplexer selecting one DATA_WIDTH word out of PORTS by a one-hot select.
module onehot_mux #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic [PORTS-1:0]            sel,
    input  logic [PORTS*DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0]       dout
);
    logic [DATA_WIDTH-1:0] masked [PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_mask
            assign masked[gi] = din[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH] & {DATA_WIDTH{sel[gi]}};
        end
    endgenerate

    always_comb begin
        dout = '0;
        for (int i = 0; i < PORTS; i++) begin
            dout = dout | masked[i];
        end
    end
endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin valid/ready stream arbiter with a registered one-hot grant.
// Define LIBSV_RR_STREAM_ARBITER_PACKET_LOCK_EN to hold the grant until i_last.
module rr_stream_arbiter
    import rr_stream_arbiter_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_aresetn,
    rr_stream_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(PORTS);

    state_t             state_reg, state_next;
    logic [PORTS-1:0]   grant_reg, grant_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next;
    logic [PTR_W-1:0]   g_idx;
    logic [PTR_W-1:0]   ptr_after;
    logic               valid_sel;
    logic               last_sel;
    logic               transfer;
    logic               release_grant;
    rr_vec_t            pick_idle;
    rr_vec_t            pick_after;

    onehot_mux #(
        .PORTS      (PORTS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_data_mux (
        .sel  (grant_reg),
        .din  (bus.i_data),
        .dout (bus.o_data)
    );

    assign valid_sel   = |(bus.i_valid & grant_reg);
    assign last_sel    = |(bus.i_last & grant_reg);
    assign bus.o_valid = valid_sel;
    assign bus.o_last  = last_sel;
    assign bus.o_ready = {PORTS{bus.i_ready}} & grant_reg;
    assign bus.o_grant = grant_reg;

    assign transfer = valid_sel & bus.i_ready;
`ifdef LIBSV_RR_STREAM_ARBITER_PACKET_LOCK_EN
    assign release_grant = transfer & last_sel;
`else
    assign release_grant = transfer | ~valid_sel;
`endif

    always_comb begin
        g_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_reg[i]) begin
                g_idx = PTR_W'(i);
            end
        end
    end

    assign ptr_after  = (g_idx == PTR_W'(PORTS-1)) ? '0 : g_idx + 1'b1;
    assign pick_idle  = rr_pick(rr_vec_t'(bus.i_valid), 32'(ptr_reg), PORTS);
    assign pick_after = rr_pick(rr_vec_t'(bus.i_valid), 32'(ptr_after), PORTS);

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (|bus.i_valid) begin
                    grant_next = pick_idle[PORTS-1:0];
                    state_next = GRANTED;
                end
            end
            GRANTED: begin
                // Re-arbitrate in the release cycle so consecutive beats need no bubble.
                if (release_grant) begin
                    ptr_next   = ptr_after;
                    grant_next = pick_after[PORTS-1:0];
                    state_next = (|bus.i_valid) ? GRANTED : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            ptr_reg   <= ptr_next;
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot0 : assert property (@(posedge i_clk) disable iff (!i_aresetn)
        $onehot0(grant_reg));
`endif

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: a round-robin reference model checked every
// cycle, plus hand-computed grant sequences for the listed scenarios.
module tb_rr_stream_arbiter;
    localparam int PORTS = 4;
    localparam int DW    = 8;
`ifdef LIBSV_RR_STREAM_ARBITER_PACKET_LOCK_EN
    localparam logic [PORTS-1:0] LAST_DEF = 4'b1111;
`else
    localparam logic [PORTS-1:0] LAST_DEF = 4'b0110;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks_total  = 0;
    int   checks_passed = 0;

    rr_stream_arbiter_if #(.PORTS(PORTS), .DATA_WIDTH(DW)) bus ();

    rr_stream_arbiter #(.PORTS(PORTS), .DATA_WIDTH(DW)) dut (
        .i_clk     (clk),
        .i_aresetn (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: granted port (-1 = none) and round-robin start position.
    int m_g   = -1;
    int m_ptr = 0;

    function automatic int rr_idx(input logic [PORTS-1:0] req, input int p);
        for (int k = 0; k < PORTS; k++) begin
            int j;
            j = (p + k) % PORTS;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit released(input int g);
        bit xfer;
        xfer = bus.i_valid[g] && bus.i_ready;
`ifdef LIBSV_RR_STREAM_ARBITER_PACKET_LOCK_EN
        return xfer && bus.i_last[g];
`else
        return xfer || !bus.i_valid[g];
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_g   <= -1;
            m_ptr <= 0;
        end else if (m_g < 0) begin
            m_g <= rr_idx(bus.i_valid, m_ptr);
        end else if (released(m_g)) begin
            m_ptr <= (m_g + 1) % PORTS;
            m_g   <= rr_idx(bus.i_valid, (m_g + 1) % PORTS);
        end
    end

    logic [PORTS-1:0] e_grant;
    logic [DW-1:0]    e_data;
    logic             e_valid, e_last;

    always @(negedge clk) begin
        if (rst_n) begin
            e_grant = (m_g < 0) ? '0 : (4'(1) << m_g);
            e_valid = (m_g >= 0) && bus.i_valid[m_g];
            e_last  = (m_g >= 0) && bus.i_last[m_g];
            e_data  = (m_g < 0) ? '0 : bus.i_data[m_g*DW +: DW];
            check("model_grant", bus.o_grant, e_grant);
            check("model_valid", bus.o_valid, e_valid);
            check("model_last",  bus.o_last,  e_last);
            check("model_data",  bus.o_data,  e_data);
            check("model_ready", bus.o_ready, bus.i_ready ? e_grant : 4'b0000);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.i_valid = '0;
        bus.i_last  = LAST_DEF;
        bus.i_ready = 1'b0;
        bus.i_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick();
        tick();
        check("rst_grant", bus.o_grant, 4'b0000);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_data",  bus.o_data,  8'h00);
        check("rst_last",  bus.o_last,  1'b0);
        check("rst_ready", bus.o_ready, 4'b0000);
        rst_n = 1'b1;

`ifndef LIBSV_RR_STREAM_ARBITER_PACKET_LOCK_EN
        // Single requester on port 2.
        bus.i_valid = 4'b0100; bus.i_ready = 1'b1; #1;
        check("t1_idle_grant", bus.o_grant, 4'b0000);
        tick();
        check("t1_grant", bus.o_grant, 4'b0100);
        check("t1_valid", bus.o_valid, 1'b1);
        check("t1_data",  bus.o_data,  8'hA2);
        check("t1_last",  bus.o_last,  1'b1);
        check("t1_ready", bus.o_ready, 4'b0100);
        tick();
        check("t1_regrant", bus.o_grant, 4'b0100);
        bus.i_valid = 4'b0000; #1;
        check("t1_withdraw_valid", bus.o_valid, 1'b0);
        tick();
        check("t1_idle", bus.o_grant, 4'b0000);
        bus.i_valid = 4'b1001; bus.i_ready = 1'b0;
        tick();
        check("t1_ptr3_grant", bus.o_grant, 4'b1000);
        check("t1_ptr3_data",  bus.o_data,  8'hA3);

        // All ports valid: one beat each, no bubbles.
        bus.i_valid = 4'b1111; bus.i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t2_grant", bus.o_grant, 32'(4'(1) << (k % 4)));
            check("t2_ready", bus.o_ready, 32'(4'(1) << (k % 4)));
            check("t2_valid", bus.o_valid, 1'b1);
        end

        // Stall on port 1 while ports 0 and 3 join.
        bus.i_valid = 4'b0010;
        tick();
        check("t3_grant", bus.o_grant, 4'b0010);
        bus.i_ready = 1'b0; bus.i_valid = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_stall_grant", bus.o_grant, 4'b0010);
            check("t3_stall_data",  bus.o_data,  8'hA1);
        end
        bus.i_ready = 1'b1;
        tick();
        check("t3_after_p3", bus.o_grant, 4'b1000);
        tick();
        check("t3_after_p0", bus.o_grant, 4'b0001);

        // Withdrawal without transfer.
        bus.i_valid = 4'b0000; bus.i_ready = 1'b0;
        tick();
        check("t4_idle_a", bus.o_grant, 4'b0000);
        bus.i_valid = 4'b0100;
        tick();
        check("t4_grant_p2", bus.o_grant, 4'b0100);
        bus.i_valid = 4'b0001;
        tick();
        check("t4_moved_p0", bus.o_grant, 4'b0001);
        bus.i_valid = 4'b0000;
        tick();
        check("t4_idle_b", bus.o_grant, 4'b0000);
        bus.i_valid = 4'b1111;
        tick();
        check("t4_ptr1_grant", bus.o_grant, 4'b0010);
        bus.i_ready = 1'b1;
        tick();
        check("t4_next_grant", bus.o_grant, 4'b0100);
`else
        bus.i_valid = 4'b1111; bus.i_ready = 1'b1;
        tick();
        tick();
`endif

        // Asynchronous reset mid-transfer, then restart from port 0.
        rst_n = 1'b0; #1;
        check("t6_rst_grant", bus.o_grant, 4'b0000);
        check("t6_rst_valid", bus.o_valid, 1'b0);
        check("t6_rst_ready", bus.o_ready, 4'b0000);
        check("t6_rst_data",  bus.o_data,  8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_restart", bus.o_grant, 4'b0001);

`ifdef LIBSV_RR_STREAM_ARBITER_PACKET_LOCK_EN
        // Three-beat packet on port 0 with a valid gap; port 1 waits.
        do_reset();
        bus.i_valid = 4'b0011; bus.i_last = 4'b0000; bus.i_ready = 1'b1;
        tick();
        check("t5_beat1", bus.o_grant, 4'b0001);
        tick();
        check("t5_hold1", bus.o_grant, 4'b0001);
        bus.i_valid = 4'b0010; #1;
        check("t5_gap_valid", bus.o_valid, 1'b0);
        tick();
        check("t5_gap_hold", bus.o_grant, 4'b0001);
        bus.i_valid = 4'b0011;
        tick();
        check("t5_hold2", bus.o_grant, 4'b0001);
        bus.i_last = 4'b0001; #1;
        check("t5_last", bus.o_last, 1'b1);
        tick();
        check("t5_next", bus.o_grant, 4'b0010);
`endif

        bus.i_valid = 4'b0000;
        tick();
        tick();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- N-port valid/ready stream arbiter with round-robin priority.
- Arbitrates among PORTS requesters and registers a one-hot grant.
- Routes the granted port's data to a single downstream stream through an instance of onehot_mux, driven by the registered grant.
- Sits in front of any shared single-consumer resource: bus master, FIFO write port, or shared datapath.

Parameters:
- PORTS, 4, number of requesting ports; must be at least 2.
- DATA_WIDTH, 8, width of one port's data word.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_aresetn  input  1  asynchronous active-low reset.
- i_data  input  PORTS*DATA_WIDTH  packed port data; port i occupies bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH].
- i_valid  input  PORTS  per-port request/valid.
- i_last  input  PORTS  per-port end-of-packet marker; ignored unless the lock feature is compiled in.
- o_ready  output  PORTS  per-port ready; equals i_ready AND o_grant[i].
- o_data  output  DATA_WIDTH  data from the granted port; '0 when no grant.
- o_valid  output  1  i_valid of the granted port; 0 when no grant.
- o_last  output  1  i_last of the granted port; 0 when no grant.
- i_ready  input  1  downstream ready.
- o_grant  output  PORTS  registered one-hot grant, or all-zero.

Behaviour:
- Reset (i_aresetn low, asynchronous): state=IDLE, o_grant='0, rr pointer=0.
- Reset consequences: o_valid=0, o_data='0, o_last=0, o_ready='0.
- Reset mid-packet drops the grant immediately. There is no recovery of the partial transfer.
- Transfer: a beat completes in any cycle where o_valid && i_ready.
- RR pick: the lowest index j in the circular order ptr, ptr+1, …, PORTS-1, 0, …, ptr-1 whose i_valid[j]=1.
- IDLE state:
  - If any i_valid is set, load o_grant with the one-hot RR pick and go to GRANTED.
  - Otherwise stay in IDLE.
  - Latency from first i_valid to o_valid is 1 cycle.
- GRANTED state, grant index g:
  - o_data/o_valid/o_last come combinationally from port g via onehot_mux.
  - Release condition, no lock: a transfer occurs, or i_valid[g]=0 (requester withdrew).
  - On release, set ptr=(g+1) mod PORTS.
  - In the same cycle, re-arbitrate among i_valid using the updated ptr, port g included.
  - If the re-arbitration picks a port, load the new grant and stay in GRANTED. This gives back-to-back beats with no bubble.
  - If it picks nothing, clear o_grant and go to IDLE.
  - Otherwise hold o_grant unchanged and keep ptr.
- Fairness: with all ports continuously valid, grants rotate 0,1,…,PORTS-1,0,… one beat each.
- A single requester holding i_valid is granted every cycle.
- The pointer wraps from PORTS-1 to 0.
- o_grant is never more than one-hot. Checked with an assertion under simulation.
- Simultaneous events:
  - A newly asserted i_valid on another port during a stall (o_valid=1, i_ready=0) does not preempt the current grant.
  - i_ready alone never changes the grant without o_valid.

Optional Feature:
- Macro: LIBSV_RR_STREAM_ARBITER_PACKET_LOCK_EN
- Defined:
  - In GRANTED, release only on a transfer with i_last[g]=1.
  - Non-last transfers keep the grant and ptr.
  - i_valid[g]=0 mid-packet holds the grant (o_valid=0) until the packet resumes. No withdrawal release.
- Undefined:
  - Per-beat arbitration exactly as in Behaviour.
  - i_last is routed to o_last only.

Decomposition:
- Package rr_stream_arbiter_pkg holds:
  - state enum (IDLE, GRANTED);
  - a rr_pick function (request vector, pointer → one-hot) parameterised via localparam width casts.
- Sub-module: onehot_mux (PORTS, DATA_WIDTH) for data.
- last and valid are selected with AND-OR reductions on o_grant.
- Pointer width is $clog2(PORTS).

Test Plan:
1. Reset, then i_valid=4'b0100, i_ready=1 → next cycle o_grant=4'b0100, o_valid=1, o_data=port2 word. After the transfer ptr=3, and with no requests the block is IDLE with o_grant=0.
2. All four ports valid, i_ready=1 for 8 cycles → o_grant sequence 0001,0010,0100,1000,0001,… with no bubble cycles and o_ready matching o_grant.
3. Port1 granted, i_ready=0 for 3 cycles while port0 and port3 assert valid → grant stays 0010 and o_data stable. On i_ready=1 the next grant is 1000 (ptr=2), then 0001.
4. Granted port2 drops i_valid without transfer (lock off) → next cycle grant moves to the next RR requester, or IDLE if none.
5. Lock on, port0 sends a 3-beat packet (i_last on beat 3) while port1 is valid → grant 0001 held for all 3 beats including a 1-cycle valid gap; 0010 follows the last beat.
6. Assert i_aresetn=0 mid-packet → o_grant, o_valid, o_ready drop in the same cycle without a clock edge. After release, arbitration restarts from port 0.
